control_sequencer: RTL and testbench
====================================

# control_sequencer

Hardwired control unit driving the existing 32-bit bus datapath. It generates, cycle by cycle, the strobe sequence that the datapath consumes: fetch T0–T2, then per-class execute steps. It sits beside `datapath`, reads the IR and a memory-ready flag, and owns every bus-out, register-in, memory and ALU-select line the datapath exposes.

## Interface
- `OPW`, default 5: opcode width, taken from `ir[31:27]`.
- `clock` input 1: single system clock, rising edge.
- `clear` input 1: asynchronous, active-high reset.
- `ir` input 32: IR contents; opcode `ir[31:27]`.
- `mem_ready` input 1: memory has data valid for `MDRin` this cycle.
- `stop` input 1: hold before next fetch while high.
- `PCout`, `IncPC`, `MARin`, `Zin`, `Zlowout`, `ZHighout`, `PCin`, `Read`, `MDRin`, `MDRout`, `IRin`, `Yin`, `HIin`, `LOin` output 1 each: datapath strobes.
- `Gra`, `Grb`, `Grc`, `Rin`, `Rout` output 1 each: register-select-and-encode strobes.
- `alu_op` output OPW: ALU function; equals opcode during ALU steps, else 0.
- `run` output 1: high except in RESET and HALT.
- `illegal` output 1: sticky; set by an undefined opcode.

## Operation
- Moore FSM. States: RESET, T0, T1, T2, T3, T4, T5, T6, HALT. Outputs decode from state plus latched opcode class. Every strobe is 0 unless listed below.
- RESET: all strobes 0, `run`=0. Next state T0.
- T0: if `stop`, hold T0 with all strobes 0. Otherwise `PCout`, `MARin`, `IncPC`, `Zin`; next T1.
- T1: `Zlowout`, `PCin`, `Read`. `MDRin` is asserted only when `mem_ready`=1. Hold T1 (`Read` held, `Zlowout`/`PCin` held) until `mem_ready`; then go to T2.
- T2: `MDRout`, `IRin`. Next state by `ir[31:27]` is sampled in T3.
- Classes and encodings (shared package):
  - Binary ALU: add 00011, sub 00100, shr 00101, shl 00110, ror 00111, rol 01000, and 01001, or 01010.
    - T3: `Grb`, `Rout`, `Yin`.
    - T4: `Grc`, `Rout`, `alu_op`, `Zin`.
    - T5: `Zlowout`, `Gra`, `Rin`; then T0.
  - Mul/div: mul 01110, div 01111.
    - T3: `Gra`, `Rout`, `Yin`.
    - T4: `Grb`, `Rout`, `alu_op`, `Zin`.
    - T5: `Zlowout`, `LOin`.
    - T6: `ZHighout`, `HIin`; then T0.
  - Unary: neg 10000, not 10001.
    - T3: `Grb`, `Rout`, `alu_op`, `Zin`.
    - T4: `Zlowout`, `Gra`, `Rin`; then T0.
  - nop 11010: T3 has no strobes; then T0.
  - halt 11011: T3 goes to HALT. HALT holds until `clear`, with `run`=0 and all strobes 0.
  - Any other opcode: behaves as nop and sets `illegal`.
- Opcode is latched into a class register at the T3 entry edge. Later `ir` changes do not affect the instruction in flight.

## Timing
- Cycles per instruction, with `mem_ready` high in T1: binary 6, mul/div 7, unary 5, nop/illegal 4.
- Each `mem_ready`-low cycle in T1 adds one cycle.
- `stop` is sampled only in T0. It never interrupts an instruction in flight.
- `clear` asserted mid-instruction: immediately forces RESET, drops all strobes and clears `illegal`. The first T0 comes one cycle after deassertion.
- Reset values: every output 0, including `run`, `illegal` and `alu_op`.
- No two bus-out strobes (`PCout`, `Zlowout`, `ZHighout`, `MDRout`, `Rout`) are high in the same state.

## Structure
- Package `cpu_ctrl_pkg`: opcode localparams, state enum, class enum (BIN, MULDIV, UNARY, NOP, HALT, ILL).
- One sub-module, `opcode_classify`: combinational opcode→class plus legality. It is reused by later decode work.
- The top module holds the state register, class latch, `illegal` flag and output decode.

## Test plan
- Reset, then `ir`=`{5'b01010,…}` (or R1,R2,R3) with `mem_ready`=1 → six cycles T0..T5. T4 shows `Grc`,`Rout`,`Zin` with `alu_op`=01010. T5 shows `Zlowout`,`Gra`,`Rin`. Next cycle is T0.
- `ir` opcode 01110 (mul) → T5 shows `LOin`,`Zlowout`. T6 shows `HIin`,`ZHighout`. 7 cycles total.
- `mem_ready` low for 3 cycles in T1 → `Read` held 4 cycles, `MDRin` high only on the 4th, instruction latency +3.
- Opcode 11111 → nop path, `illegal`=1 from T3 onward. Staying 1 across the next add; `clear` returns it to 0.
- `stop`=1 during T4 of add → completes T5, then holds in T0 with no strobes. `stop`=0 resumes fetch next cycle.
- Opcode 11011 (halt) → HALT with `run`=0 indefinitely. `clear` pulse mid-T4 of a later run → all outputs 0 that same edge, T0 one cycle after release.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared control-unit definitions: opcode encodings, sequencer states and
// the opcode classes the decode logic sorts instructions into.
package cpu_ctrl_pkg;

    localparam int OPC_W = 5;

    localparam logic [OPC_W-1:0] OP_ADD  = 5'b00011;
    localparam logic [OPC_W-1:0] OP_SUB  = 5'b00100;
    localparam logic [OPC_W-1:0] OP_SHR  = 5'b00101;
    localparam logic [OPC_W-1:0] OP_SHL  = 5'b00110;
    localparam logic [OPC_W-1:0] OP_ROR  = 5'b00111;
    localparam logic [OPC_W-1:0] OP_ROL  = 5'b01000;
    localparam logic [OPC_W-1:0] OP_AND  = 5'b01001;
    localparam logic [OPC_W-1:0] OP_OR   = 5'b01010;
    localparam logic [OPC_W-1:0] OP_MUL  = 5'b01110;
    localparam logic [OPC_W-1:0] OP_DIV  = 5'b01111;
    localparam logic [OPC_W-1:0] OP_NEG  = 5'b10000;
    localparam logic [OPC_W-1:0] OP_NOT  = 5'b10001;
    localparam logic [OPC_W-1:0] OP_NOP  = 5'b11010;
    localparam logic [OPC_W-1:0] OP_HALT = 5'b11011;

    typedef enum logic [3:0] {
        S_RESET,
        S_T0,
        S_T1,
        S_T2,
        S_T3,
        S_T4,
        S_T5,
        S_T6,
        S_HALT
    } state_t;

    typedef enum logic [2:0] {
        C_BIN,
        C_MULDIV,
        C_UNARY,
        C_NOP,
        C_HALT,
        C_ILL
    } op_class_t;

endpackage

// File: rtl/opcode_classify.sv
// Combinational opcode-to-class decode with a legality flag; undefined
// opcodes fall into the illegal class so the sequencer can treat them as nop.
module opcode_classify
    import cpu_ctrl_pkg::*;
(
    input  logic [OPC_W-1:0] opcode,
    output op_class_t        op_class,
    output logic             legal
);

    // Sort the opcode into its execute class; anything unlisted is illegal.
    always_comb begin
        op_class = C_ILL;
        legal    = 1'b1;
        case (opcode)
            OP_ADD, OP_SUB, OP_SHR, OP_SHL,
            OP_ROR, OP_ROL, OP_AND, OP_OR:   op_class = C_BIN;
            OP_MUL, OP_DIV:                  op_class = C_MULDIV;
            OP_NEG, OP_NOT:                  op_class = C_UNARY;
            OP_NOP:                          op_class = C_NOP;
            OP_HALT:                         op_class = C_HALT;
            default:                         legal    = 1'b0;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control unit for the 32-bit bus datapath: fetch in T0-T2, then
// class-dependent execute steps. The opcode and its class are captured when
// leaving T2 so later IR changes cannot disturb the instruction in flight.
module control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int OPW = 5
)
(
    input  logic           clock,
    input  logic           clear,
    input  logic [31:0]    ir,
    input  logic           mem_ready,
    input  logic           stop,
    output logic           PCout,
    output logic           IncPC,
    output logic           MARin,
    output logic           Zin,
    output logic           Zlowout,
    output logic           ZHighout,
    output logic           PCin,
    output logic           Read,
    output logic           MDRin,
    output logic           MDRout,
    output logic           IRin,
    output logic           Yin,
    output logic           HIin,
    output logic           LOin,
    output logic           Gra,
    output logic           Grb,
    output logic           Grc,
    output logic           Rin,
    output logic           Rout,
    output logic [OPW-1:0] alu_op,
    output logic           run,
    output logic           illegal
);

    state_t          state;
    state_t          state_next;
    op_class_t       cls_dec;
    op_class_t       cls_q;
    logic            legal_dec;
    logic [OPW-1:0]  op_q;

    opcode_classify u_classify (
        .opcode   (ir[31:27]),
        .op_class (cls_dec),
        .legal    (legal_dec)
    );

    // State register; clear drops straight back to RESET.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) state <= S_RESET;
        else       state <= state_next;
    end

    // Capture opcode and class on the T2->T3 edge; illegal is sticky until clear.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            cls_q   <= C_NOP;
            op_q    <= '0;
            illegal <= 1'b0;
        end else if (state == S_T2) begin
            cls_q <= cls_dec;
            op_q  <= ir[31 -: OPW];
            if (!legal_dec) illegal <= 1'b1;
        end
    end

    // Next-state: fetch waits on stop and mem_ready, execute length follows the class.
    always_comb begin
        state_next = S_RESET;
        case (state)
            S_RESET: state_next = S_T0;
            S_T0:    state_next = stop ? S_T0 : S_T1;
            S_T1:    state_next = mem_ready ? S_T2 : S_T1;
            S_T2:    state_next = S_T3;
            S_T3: begin
                case (cls_q)
                    C_BIN, C_MULDIV, C_UNARY: state_next = S_T4;
                    C_HALT:                   state_next = S_HALT;
                    default:                  state_next = S_T0;
                endcase
            end
            S_T4:    state_next = (cls_q == C_BIN || cls_q == C_MULDIV) ? S_T5 : S_T0;
            S_T5:    state_next = (cls_q == C_MULDIV) ? S_T6 : S_T0;
            S_T6:    state_next = S_T0;
            S_HALT:  state_next = S_HALT;
            default: state_next = S_RESET;
        endcase
    end

    // Strobe decode from state and latched class; at most one bus driver per state.
    always_comb begin
        PCout    = 1'b0;
        IncPC    = 1'b0;
        MARin    = 1'b0;
        Zin      = 1'b0;
        Zlowout  = 1'b0;
        ZHighout = 1'b0;
        PCin     = 1'b0;
        Read     = 1'b0;
        MDRin    = 1'b0;
        MDRout   = 1'b0;
        IRin     = 1'b0;
        Yin      = 1'b0;
        HIin     = 1'b0;
        LOin     = 1'b0;
        Gra      = 1'b0;
        Grb      = 1'b0;
        Grc      = 1'b0;
        Rin      = 1'b0;
        Rout     = 1'b0;
        alu_op   = '0;
        run      = (state != S_RESET) && (state != S_HALT);
        case (state)
            S_T0: begin
                if (!stop) begin
                    PCout = 1'b1;
                    MARin = 1'b1;
                    IncPC = 1'b1;
                    Zin   = 1'b1;
                end
            end
            S_T1: begin
                Zlowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = mem_ready;
            end
            S_T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            S_T3: begin
                case (cls_q)
                    C_BIN: begin
                        Grb  = 1'b1;
                        Rout = 1'b1;
                        Yin  = 1'b1;
                    end
                    C_MULDIV: begin
                        Gra  = 1'b1;
                        Rout = 1'b1;
                        Yin  = 1'b1;
                    end
                    C_UNARY: begin
                        Grb    = 1'b1;
                        Rout   = 1'b1;
                        Zin    = 1'b1;
                        alu_op = op_q;
                    end
                    default: ;
                endcase
            end
            S_T4: begin
                case (cls_q)
                    C_BIN: begin
                        Grc    = 1'b1;
                        Rout   = 1'b1;
                        Zin    = 1'b1;
                        alu_op = op_q;
                    end
                    C_MULDIV: begin
                        Grb    = 1'b1;
                        Rout   = 1'b1;
                        Zin    = 1'b1;
                        alu_op = op_q;
                    end
                    C_UNARY: begin
                        Zlowout = 1'b1;
                        Gra     = 1'b1;
                        Rin     = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T5: begin
                case (cls_q)
                    C_BIN: begin
                        Zlowout = 1'b1;
                        Gra     = 1'b1;
                        Rin     = 1'b1;
                    end
                    C_MULDIV: begin
                        Zlowout = 1'b1;
                        LOin    = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T6: begin
                ZHighout = 1'b1;
                HIin     = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Randomized bench for control_sequencer. Expected strobe vectors come from
// per-class step tables and the fetch rules, one vector per clock cycle.
module tb_control_sequencer;

    logic        clock = 1'b0;
    logic        clear;
    logic [31:0] ir;
    logic        mem_ready;
    logic        stop;
    logic        PCout, IncPC, MARin, Zin, Zlowout, ZHighout, PCin, Read, MDRin;
    logic        MDRout, IRin, Yin, HIin, LOin, Gra, Grb, Grc, Rin, Rout;
    logic [4:0]  alu_op;
    logic        run;
    logic        illegal;

    int check_count = 0;
    int pass_count  = 0;
    int instr_idx   = 0;
    bit ill_m       = 1'b0;

    // One-hot strobe positions, PCout at the top down to Rout at bit 0.
    localparam logic [18:0] K_PCOUT  = 19'd1 << 18;
    localparam logic [18:0] K_INCPC  = 19'd1 << 17;
    localparam logic [18:0] K_MARIN  = 19'd1 << 16;
    localparam logic [18:0] K_ZIN    = 19'd1 << 15;
    localparam logic [18:0] K_ZLOW   = 19'd1 << 14;
    localparam logic [18:0] K_ZHIGH  = 19'd1 << 13;
    localparam logic [18:0] K_PCIN   = 19'd1 << 12;
    localparam logic [18:0] K_READ   = 19'd1 << 11;
    localparam logic [18:0] K_MDRIN  = 19'd1 << 10;
    localparam logic [18:0] K_MDROUT = 19'd1 << 9;
    localparam logic [18:0] K_IRIN   = 19'd1 << 8;
    localparam logic [18:0] K_YIN    = 19'd1 << 7;
    localparam logic [18:0] K_HIIN   = 19'd1 << 6;
    localparam logic [18:0] K_LOIN   = 19'd1 << 5;
    localparam logic [18:0] K_GRA    = 19'd1 << 4;
    localparam logic [18:0] K_GRB    = 19'd1 << 3;
    localparam logic [18:0] K_GRC    = 19'd1 << 2;
    localparam logic [18:0] K_RIN    = 19'd1 << 1;
    localparam logic [18:0] K_ROUT   = 19'd1 << 0;
    localparam logic [18:0] K_BUS    = K_PCOUT | K_ZLOW | K_ZHIGH | K_MDROUT | K_ROUT;

    logic [18:0] step_s [4];
    bit          step_a [4];
    int          step_n;

    control_sequencer #(.OPW(5)) dut (
        .clock     (clock),
        .clear     (clear),
        .ir        (ir),
        .mem_ready (mem_ready),
        .stop      (stop),
        .PCout     (PCout),
        .IncPC     (IncPC),
        .MARin     (MARin),
        .Zin       (Zin),
        .Zlowout   (Zlowout),
        .ZHighout  (ZHighout),
        .PCin      (PCin),
        .Read      (Read),
        .MDRin     (MDRin),
        .MDRout    (MDRout),
        .IRin      (IRin),
        .Yin       (Yin),
        .HIin      (HIin),
        .LOin      (LOin),
        .Gra       (Gra),
        .Grb       (Grb),
        .Grc       (Grc),
        .Rin       (Rin),
        .Rout      (Rout),
        .alu_op    (alu_op),
        .run       (run),
        .illegal   (illegal)
    );

    always #5 clock = ~clock;

    function automatic logic [18:0] strobes_now();
        return {PCout, IncPC, MARin, Zin, Zlowout, ZHighout, PCin, Read, MDRin,
                MDRout, IRin, Yin, HIin, LOin, Gra, Grb, Grc, Rin, Rout};
    endfunction

    function automatic logic [31:0] obs_vec();
        return {6'd0, run, illegal, alu_op, strobes_now()};
    endfunction

    function automatic logic [31:0] mkexp(input bit run_e, input bit ill_e,
                                          input logic [4:0] alu, input logic [18:0] s);
        return {6'd0, run_e, ill_e, alu, s};
    endfunction

    function automatic bit is_legal(input logic [4:0] op);
        return op inside {5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10,
                          5'd14, 5'd15, 5'd16, 5'd17, 5'd26, 5'd27};
    endfunction

    function automatic bit rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_count++;
        if (obs !== exp)
            $display("[TB] FAIL %s (instr %0d): got %h expected %h", tag, instr_idx, obs, exp);
        else
            pass_count++;
    endtask

    // Called just after a rising edge: drive inputs, check mid-cycle, advance one clock.
    task automatic apply_stimulus(input bit st, input bit mr, input logic [31:0] irv,
                                  input logic [31:0] exp, input string tag);
        stop      = st;
        mem_ready = mr;
        ir        = irv;
        @(negedge clock);
        check_output(tag, obs_vec(), exp);
        check_output("bus1", 32'($countones(strobes_now() & K_BUS) <= 1), 32'd1);
        @(posedge clock);
        #1;
    endtask

    // Execute step table for each instruction class.
    task automatic build_steps(input logic [4:0] op);
        for (int i = 0; i < 4; i++) begin
            step_s[i] = '0;
            step_a[i] = 1'b0;
        end
        if (op inside {5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10}) begin
            step_n = 3;
            step_s[0] = K_GRB | K_ROUT | K_YIN;
            step_s[1] = K_GRC | K_ROUT | K_ZIN;  step_a[1] = 1'b1;
            step_s[2] = K_ZLOW | K_GRA | K_RIN;
        end else if (op inside {5'd14, 5'd15}) begin
            step_n = 4;
            step_s[0] = K_GRA | K_ROUT | K_YIN;
            step_s[1] = K_GRB | K_ROUT | K_ZIN;  step_a[1] = 1'b1;
            step_s[2] = K_ZLOW | K_LOIN;
            step_s[3] = K_ZHIGH | K_HIIN;
        end else if (op inside {5'd16, 5'd17}) begin
            step_n = 2;
            step_s[0] = K_GRB | K_ROUT | K_ZIN;  step_a[0] = 1'b1;
            step_s[1] = K_ZLOW | K_GRA | K_RIN;
        end else begin
            step_n = 1;
        end
    endtask

    // Pulse clear mid-cycle: outputs must drop at once, then one RESET cycle follows.
    task automatic do_clear();
        clear = 1'b1;
        #1;
        check_output("clr", obs_vec(), 32'd0);
        ill_m = 1'b0;
        @(posedge clock);
        #1;
        clear = 1'b0;
        apply_stimulus(rb(), rb(), $urandom, 32'd0, "rst");
    endtask

    // One instruction: k stop cycles in T0, w not-ready cycles in T1, optional clear at a step.
    task automatic run_instr(input logic [4:0] op, input int k, input int w, input int abort_step);
        instr_idx++;
        build_steps(op);
        for (int i = 0; i < k; i++)
            apply_stimulus(1'b1, rb(), $urandom, mkexp(1, ill_m, 5'd0, '0), "t0stop");
        apply_stimulus(1'b0, rb(), $urandom,
                       mkexp(1, ill_m, 5'd0, K_PCOUT | K_MARIN | K_INCPC | K_ZIN), "t0");
        for (int i = 0; i < w; i++)
            apply_stimulus(rb(), 1'b0, $urandom,
                           mkexp(1, ill_m, 5'd0, K_ZLOW | K_PCIN | K_READ), "t1wait");
        apply_stimulus(rb(), 1'b1, $urandom,
                       mkexp(1, ill_m, 5'd0, K_ZLOW | K_PCIN | K_READ | K_MDRIN), "t1");
        apply_stimulus(rb(), rb(), {op, 27'($urandom)},
                       mkexp(1, ill_m, 5'd0, K_MDROUT | K_IRIN), "t2");
        if (!is_legal(op)) ill_m = 1'b1;
        for (int s = 0; s < step_n; s++) begin
            if (s == abort_step) begin
                stop      = rb();
                mem_ready = rb();
                ir        = $urandom;
                #2;
                check_output("preclr", obs_vec(),
                             mkexp(1, ill_m, step_a[s] ? op : 5'd0, step_s[s]));
                do_clear();
                return;
            end
            apply_stimulus(rb(), rb(), $urandom,
                           mkexp(1, ill_m, step_a[s] ? op : 5'd0, step_s[s]), "exec");
        end
    endtask

    function automatic logic [4:0] pick_op();
        logic [4:0] bin_ops [8];
        logic [4:0] op;
        bin_ops = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10};
        case ($urandom_range(0, 9))
            0, 1, 2, 7:  op = bin_ops[$urandom_range(0, 7)];
            3, 8:        op = 5'd14 + 5'($urandom_range(0, 1));
            4, 9:        op = 5'd16 + 5'($urandom_range(0, 1));
            5:           op = 5'd26;
            default: begin
                op = 5'($urandom);
                while (is_legal(op)) op = 5'($urandom);
            end
        endcase
        return op;
    endfunction

    // Directed scenarios first, then a randomized instruction stream.
    initial begin
        clear     = 1'b0;
        stop      = 1'b0;
        mem_ready = 1'b0;
        ir        = '0;
        #1 clear = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check_output("reset", obs_vec(), 32'd0);
        clear = 1'b0;
        apply_stimulus(1'b0, 1'b1, $urandom, 32'd0, "rst");

        run_instr(5'b01010, 0, 0, -1);
        run_instr(5'b01110, 0, 0, -1);
        run_instr(5'b00011, 0, 3, -1);
        run_instr(5'b11111, 0, 0, -1);
        run_instr(5'b00011, 0, 0, -1);
        run_instr(5'b10001, 2, 1, -1);
        do_clear();
        run_instr(5'b11010, 1, 0, -1);

        for (int n = 0; n < 150; n++)
            run_instr(pick_op(), $urandom_range(0, 2), $urandom_range(0, 3), -1);

        run_instr(5'b11011, 0, 0, -1);
        repeat (6) apply_stimulus(rb(), rb(), $urandom, mkexp(0, ill_m, 5'd0, '0), "halt");
        do_clear();

        run_instr(5'b00100, 0, 0, 1);
        run_instr(5'b01111, 0, 2, 3);
        run_instr(5'b00111, 0, 0, -1);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
